// File: rtl/thermo_level_ctrl_pkg.sv
// Shared op codes, FSM state encodings and defaults for the thermometer level sequencer.
package thermo_level_ctrl_pkg;

  localparam int DEF_MAX_LEVEL = 10;

  typedef enum logic [1:0] {
    OP_SET    = 2'b00,
    OP_RAMP   = 2'b01,
    OP_BOUNCE = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RAMP = 2'b01,
    ST_BUP  = 2'b10,
    ST_BDN  = 2'b11
  } state_e;

endpackage

// File: rtl/thermo_level_ctrl_step_prescaler.sv
// Level-step prescaler: counts 0..CLK_DIV-1 while enabled, tick on the last count.
module step_prescaler #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Next count: clear wins, hold at 0 when disabled, wrap after the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en)  cnt_d = '0;
    else if (tick)   cnt_d = '0;
    else             cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/thermo_level_ctrl.sv
// Command sequencer for the 10-LED thermometer bar: SET / RAMP / BOUNCE over valid/ready.
module thermo_level_ctrl
  import thermo_level_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 50_000_000,
  parameter int MAX_LEVEL = DEF_MAX_LEVEL,
  parameter int LEVEL_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEVEL_W-1:0] cmd_target,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output logic               done
);

  localparam logic [LEVEL_W-1:0] LMAX = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] ONE  = LEVEL_W'(1);

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] tgt_q, tgt_d;
  logic               fin_q, fin_d;   // command finished this edge; done follows one clk later
  logic               done_q, busy_q;
  logic               accept, tick;
  logic [LEVEL_W-1:0] cmd_tgt;
  op_e                op;

  assign cmd_ready = (state_q != ST_RAMP);
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_tgt   = (cmd_target > LMAX) ? LMAX : cmd_target;
  assign op        = op_e'(cmd_op);
  assign level     = level_q;
  assign busy      = busy_q;
  assign done      = done_q;

  step_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state_q != ST_IDLE),
    .tick  (tick)
  );

  // Next-state / level decode; a new command takes priority over a coincident tick.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    tgt_d   = tgt_q;
    fin_d   = 1'b0;
    if (accept) begin
      unique case (op)
        OP_SET: begin
          tgt_d   = cmd_tgt;
          level_d = cmd_tgt;
          state_d = ST_IDLE;
          fin_d   = 1'b1;
        end
        OP_RAMP: begin
          tgt_d = cmd_tgt;
          if (cmd_tgt == level_q) begin
            state_d = ST_IDLE;
            fin_d   = 1'b1;
          end else begin
            state_d = ST_RAMP;
          end
        end
        OP_BOUNCE: begin
          tgt_d   = cmd_tgt;
          state_d = ST_BUP;
          if (cmd_tgt == '0) level_d = '0;
        end
        default: ;  // reserved: handshake only
      endcase
    end else if (tick) begin
      unique case (state_q)
        ST_RAMP: begin
          level_d = (level_q < tgt_q) ? level_q + ONE : level_q - ONE;
          if (level_d == tgt_q) begin
            state_d = ST_IDLE;
            fin_d   = 1'b1;
          end
        end
        ST_BUP: begin
          if (tgt_q == '0) begin
            level_d = '0;                       // zero-height sweep holds at 0
          end else if (level_q < tgt_q) begin
            level_d = level_q + ONE;
            if (level_d == tgt_q) state_d = ST_BDN;
          end else begin
            // Started at/above the peak (bounce issued from a high level): head down.
            level_d = level_q - ONE;
            state_d = (level_d == '0) ? ST_BUP : ST_BDN;
          end
        end
        ST_BDN: begin
          if (level_q != '0) level_d = level_q - ONE;
          if (level_d == '0) state_d = ST_BUP;
        end
        default: ;
      endcase
    end
  end

  // State, level and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      tgt_q   <= '0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      tgt_q   <= tgt_d;
      fin_q   <= fin_d;
      done_q  <= fin_q;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_thermo_level_ctrl.sv
// Directed bench for thermo_level_ctrl with CLK_DIV=4; outputs sampled on falling edges.
module tb_thermo_level_ctrl;

  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [LW-1:0] cmd_target = '0;
  logic [LW-1:0] level;
  logic          busy, done;

  int nchk = 0;
  int nerr = 0;
  int ndone = 0;

  always #5 clk = ~clk;

  thermo_level_ctrl #(.CLK_DIV(4), .MAX_LEVEL(10), .LEVEL_W(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_target (cmd_target),
    .level      (level),
    .busy       (busy),
    .done       (done)
  );

  always @(negedge clk) if (done) ndone++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one command at a falling edge, return at the falling edge after accept.
  task automatic issue(input logic [1:0] op, input logic [LW-1:0] t);
    int w;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", 32'(cmd_ready), 1);
      return;
    end
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_target = t;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int d0;
    int exp_b[7];
    exp_b = '{1, 2, 3, 2, 1, 0, 1};

    // 1: reset
    cyc(2);
    chk("rst_level", 32'(level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_level", 32'(level), 0);
    chk("post_rst_ready", 32'(cmd_ready), 1);

    // 2: SET 7, SET 15 (clamped)
    d0 = ndone;
    issue(2'b00, 4'd7);
    chk("set7_level", 32'(level), 7);
    chk("set7_done_early", 32'(done), 0);
    chk("set7_busy", 32'(busy), 0);
    cyc(1);
    chk("set7_done", 32'(done), 1);
    cyc(1);
    chk("set7_done_off", 32'(done), 0);
    chk("set7_done_cnt", 32'(ndone - d0), 1);
    issue(2'b00, 4'd15);
    chk("set15_clamp", 32'(level), 10);
    cyc(3);

    // 3: RAMP 0 -> 5, then RAMP 5 again
    issue(2'b00, 4'd0);
    cyc(3);
    d0 = ndone;
    issue(2'b01, 4'd5);
    chk("ramp_ready", 32'(cmd_ready), 0);
    chk("ramp_busy", 32'(busy), 1);
    cyc(3);
    chk("ramp_pre_step", 32'(level), 0);
    cyc(1);
    chk("ramp_step1", 32'(level), 1);
    for (int k = 2; k <= 5; k++) begin
      cyc(4);
      chk("ramp_step", 32'(level), 32'(k));
    end
    chk("ramp_end_ready", 32'(cmd_ready), 1);
    chk("ramp_end_busy", 32'(busy), 0);
    chk("ramp_done_early", 32'(done), 0);
    cyc(1);
    chk("ramp_done", 32'(done), 1);
    cyc(1);
    chk("ramp_done_off", 32'(done), 0);
    chk("ramp_done_cnt", 32'(ndone - d0), 1);
    issue(2'b01, 4'd5);
    chk("ramp_same_level", 32'(level), 5);
    chk("ramp_same_busy", 32'(busy), 0);
    cyc(1);
    chk("ramp_same_done", 32'(done), 1);
    cyc(2);

    // 4: BOUNCE 3 from 0, SET 8 mid-sweep
    issue(2'b00, 4'd0);
    cyc(3);
    d0 = ndone;
    issue(2'b10, 4'd3);
    chk("bnc_busy", 32'(busy), 1);
    chk("bnc_ready", 32'(cmd_ready), 1);
    for (int k = 0; k < 7; k++) begin
      cyc(4);
      chk("bnc_level", 32'(level), 32'(exp_b[k]));
    end
    chk("bnc_no_done", 32'(ndone - d0), 0);
    cyc(2);
    issue(2'b00, 4'd8);
    chk("bnc_set8_level", 32'(level), 8);
    chk("bnc_set8_busy", 32'(busy), 0);
    cyc(3);

    // 5: RAMP 0 from 10, reset at level 6, then RAMP 2
    issue(2'b00, 4'd10);
    cyc(3);
    d0 = ndone;
    issue(2'b01, 4'd0);
    chk("rr_start", 32'(level), 10);
    cyc(16);
    chk("rr_at6", 32'(level), 6);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_async_level", 32'(level), 0);
    chk("rr_async_busy", 32'(busy), 0);
    chk("rr_async_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    chk("rr_no_done", 32'(ndone - d0), 0);
    d0 = ndone;
    issue(2'b01, 4'd2);
    chk("rr2_busy", 32'(busy), 1);
    cyc(8);
    chk("rr2_level", 32'(level), 2);
    cyc(1);
    chk("rr2_done", 32'(done), 1);
    cyc(2);
    chk("rr2_done_cnt", 32'(ndone - d0), 1);

    // 6: reserved op, BOUNCE 0
    issue(2'b00, 4'd4);
    cyc(3);
    d0 = ndone;
    issue(2'b11, 4'd9);
    chk("rsvd_level", 32'(level), 4);
    chk("rsvd_busy", 32'(busy), 0);
    cyc(6);
    chk("rsvd_level_hold", 32'(level), 4);
    chk("rsvd_no_done", 32'(ndone - d0), 0);
    issue(2'b10, 4'd0);
    chk("b0_level", 32'(level), 0);
    chk("b0_busy", 32'(busy), 1);
    cyc(13);
    chk("b0_hold", 32'(level), 0);
    chk("b0_busy_hold", 32'(busy), 1);
    chk("b0_no_done", 32'(ndone - d0), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
